// File: rtl/alu_exec_pipe_if.sv
// rtl/alu_exec_pipe_if.sv - issue, bypass, flush and result handshake bundle for alu_exec_pipe
interface alu_exec_pipe_if #(
    parameter int DATA_W  = 32,
    parameter int REG_AW  = 7,
    parameter int ROB_AW  = 6,
    parameter int NUM_BYP = 5,
    parameter int DEPTH   = 2
);
    logic                        Flush;

    logic                        In_Valid;
    logic                        In_Ready;
    logic [DATA_W-1:0]           In_Pc;
    logic [4:0]                  In_Op;
    logic                        In_Src1Able;
    logic [REG_AW-1:0]           In_Src1Addr;
    logic [DATA_W-1:0]           In_Src1Data;
    logic                        In_Src2Able;
    logic [REG_AW-1:0]           In_Src2Addr;
    logic [DATA_W-1:0]           In_Src2Data;
    logic [19:0]                 In_Imm;
    logic                        In_RdAble;
    logic [REG_AW-1:0]           In_RdAddr;
    logic [ROB_AW-1:0]           In_RobPtr;

    logic [NUM_BYP-1:0]          Byp_Able;
    logic [NUM_BYP*REG_AW-1:0]   Byp_Addr;
    logic [NUM_BYP*DATA_W-1:0]   Byp_Data;

    logic                        Out_Valid;
    logic                        Out_Ready;
    logic                        Out_WBAble;
    logic [REG_AW-1:0]           Out_WBAddr;
    logic [DATA_W-1:0]           Out_WBData;
    logic [ROB_AW-1:0]           Out_RobPtr;
    logic [1:0]                  Out_Type;
    logic [$clog2(DEPTH+1)-1:0]  Occupancy;

    modport master (
        output Flush,
        output In_Valid, In_Pc, In_Op,
        output In_Src1Able, In_Src1Addr, In_Src1Data,
        output In_Src2Able, In_Src2Addr, In_Src2Data,
        output In_Imm, In_RdAble, In_RdAddr, In_RobPtr,
        output Byp_Able, Byp_Addr, Byp_Data,
        output Out_Ready,
        input  In_Ready,
        input  Out_Valid, Out_WBAble, Out_WBAddr, Out_WBData, Out_RobPtr, Out_Type,
        input  Occupancy
    );

    modport slave (
        input  Flush,
        input  In_Valid, In_Pc, In_Op,
        input  In_Src1Able, In_Src1Addr, In_Src1Data,
        input  In_Src2Able, In_Src2Addr, In_Src2Data,
        input  In_Imm, In_RdAble, In_RdAddr, In_RobPtr,
        input  Byp_Able, Byp_Addr, Byp_Data,
        input  Out_Ready,
        output In_Ready,
        output Out_Valid, Out_WBAble, Out_WBAddr, Out_WBData, Out_RobPtr, Out_Type,
        output Occupancy
    );
endinterface

// File: rtl/alu_exec_pipe.sv
// rtl/alu_exec_pipe.sv - single-cycle integer ALU with operand bypass feeding a small result FIFO
module alu_exec_pipe #(
    parameter int DATA_W  = 32,
    parameter int REG_AW  = 7,
    parameter int ROB_AW  = 6,
    parameter int NUM_BYP = 5,
    parameter int DEPTH   = 2
) (
    input  logic          Clk,
    input  logic          Rest,
    alu_exec_pipe_if.slave bus
);
    localparam int SH_W  = $clog2(DATA_W);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH + 1);

    typedef enum logic [4:0] {
        OP_ADD   = 5'd0,  OP_SUB   = 5'd1,  OP_ADDI  = 5'd2,  OP_LU12I = 5'd3,
        OP_SLT   = 5'd4,  OP_SLTU  = 5'd5,  OP_SLTI  = 5'd6,  OP_SLTUI = 5'd7,
        OP_PCADD = 5'd8,  OP_AND   = 5'd9,  OP_OR    = 5'd10, OP_NOR   = 5'd11,
        OP_XOR   = 5'd12, OP_ANDI  = 5'd13, OP_ORI   = 5'd14, OP_XORI  = 5'd15,
        OP_SLL   = 5'd16, OP_SRL   = 5'd17, OP_SRA   = 5'd18, OP_SLLI  = 5'd19,
        OP_SRLI  = 5'd20, OP_SRAI  = 5'd21
    } op_e;

    logic [OCC_W-1:0]  occ;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              in_ready;
    logic              out_valid;
    logic              push;
    logic              pop;

    logic              sb_able;
    logic [REG_AW-1:0] sb_addr;
    logic [DATA_W-1:0] sb_data;

    logic              q_able [DEPTH];
    logic [REG_AW-1:0] q_addr [DEPTH];
    logic [DATA_W-1:0] q_data [DEPTH];
    logic [ROB_AW-1:0] q_rob  [DEPTH];
    logic [1:0]        q_type [DEPTH];

    logic [DATA_W-1:0] opa;
    logic [DATA_W-1:0] opb;
    logic              hit_a;
    logic              hit_b;
    logic [DATA_W-1:0] imm_sext;
    logic [DATA_W-1:0] imm_zext;
    logic [DATA_W-1:0] imm_up;
    logic [SH_W-1:0]   sh_reg;
    logic [SH_W-1:0]   sh_imm;
    logic [DATA_W-1:0] res;
    logic              illegal;
    logic              res_able;
    logic [1:0]        res_type;

    // Ready depends only on registered occupancy, so Out_Ready never reaches In_Ready.
    assign in_ready  = (occ < OCC_W'(DEPTH));
    assign out_valid = (occ != '0);
    assign push      = bus.In_Valid && in_ready && !bus.Flush;
    assign pop       = out_valid && bus.Out_Ready && !bus.Flush;

    // Operand select: last pushed result first, then lowest-numbered bypass channel, else RF read.
    always_comb begin
        opa   = bus.In_Src1Data;
        opb   = bus.In_Src2Data;
        hit_a = 1'b0;
        hit_b = 1'b0;
        if (bus.In_Src1Able && sb_able && (sb_addr == bus.In_Src1Addr)) begin
            opa   = sb_data;
            hit_a = 1'b1;
        end
        if (bus.In_Src2Able && sb_able && (sb_addr == bus.In_Src2Addr)) begin
            opb   = sb_data;
            hit_b = 1'b1;
        end
        for (int c = 0; c < NUM_BYP; c++) begin
            if (!hit_a && bus.In_Src1Able && bus.Byp_Able[c] &&
                (bus.Byp_Addr[c*REG_AW +: REG_AW] == bus.In_Src1Addr)) begin
                opa   = bus.Byp_Data[c*DATA_W +: DATA_W];
                hit_a = 1'b1;
            end
            if (!hit_b && bus.In_Src2Able && bus.Byp_Able[c] &&
                (bus.Byp_Addr[c*REG_AW +: REG_AW] == bus.In_Src2Addr)) begin
                opb   = bus.Byp_Data[c*DATA_W +: DATA_W];
                hit_b = 1'b1;
            end
        end
    end

    always_comb begin
        imm_sext = {{(DATA_W-12){bus.In_Imm[11]}}, bus.In_Imm[11:0]};
        imm_zext = {{(DATA_W-12){1'b0}}, bus.In_Imm[11:0]};
        imm_up   = DATA_W'({bus.In_Imm, 12'h000});
        sh_reg   = opb[SH_W-1:0];
        sh_imm   = bus.In_Imm[SH_W-1:0];
        res      = '0;
        illegal  = 1'b0;
        case (bus.In_Op)
            OP_ADD:   res = opa + opb;
            OP_SUB:   res = opa - opb;
            OP_ADDI:  res = opa + imm_sext;
            OP_LU12I: res = imm_up;
            OP_SLT:   res = {{(DATA_W-1){1'b0}}, ($signed(opa) < $signed(opb))};
            OP_SLTU:  res = {{(DATA_W-1){1'b0}}, (opa < opb)};
            OP_SLTI:  res = {{(DATA_W-1){1'b0}}, ($signed(opa) < $signed(imm_sext))};
            OP_SLTUI: res = {{(DATA_W-1){1'b0}}, (opa < imm_zext)};
            OP_PCADD: res = bus.In_Pc + imm_up;
            OP_AND:   res = opa & opb;
            OP_OR:    res = opa | opb;
            OP_NOR:   res = ~(opa | opb);
            OP_XOR:   res = opa ^ opb;
            OP_ANDI:  res = opa & imm_zext;
            OP_ORI:   res = opa | imm_zext;
            OP_XORI:  res = opa ^ imm_zext;
            OP_SLL:   res = opa << sh_reg;
            OP_SRL:   res = opa >> sh_reg;
            OP_SRA:   res = $signed(opa) >>> sh_reg;
            OP_SLLI:  res = opa << sh_imm;
            OP_SRLI:  res = opa >> sh_imm;
            OP_SRAI:  res = $signed(opa) >>> sh_imm;
            default:  illegal = 1'b1;
        endcase
        res_able = bus.In_RdAble && !illegal;
        res_type = illegal ? 2'b11 : 2'b00;
    end

    always_ff @(posedge Clk) begin
        if (Rest || bus.Flush) begin
            occ     <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            sb_able <= 1'b0;
            sb_addr <= '0;
            sb_data <= '0;
        end else begin
            if (push) begin
                wr_ptr  <= wr_ptr + PTR_W'(1);
                sb_able <= res_able;
                sb_addr <= bus.In_RdAddr;
                sb_data <= res;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   occ <= occ + OCC_W'(1);
                2'b01:   occ <= occ - OCC_W'(1);
                default: occ <= occ;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (push) begin
            q_able[wr_ptr] <= res_able;
            q_addr[wr_ptr] <= bus.In_RdAddr;
            q_data[wr_ptr] <= res;
            q_rob[wr_ptr]  <= bus.In_RobPtr;
            q_type[wr_ptr] <= res_type;
        end
    end

    // Storage is not reset; head fields are masked so an empty buffer presents zeros.
    assign bus.In_Ready   = in_ready;
    assign bus.Out_Valid  = out_valid;
    assign bus.Out_WBAble = out_valid ? q_able[rd_ptr] : 1'b0;
    assign bus.Out_WBAddr = out_valid ? q_addr[rd_ptr] : '0;
    assign bus.Out_WBData = out_valid ? q_data[rd_ptr] : '0;
    assign bus.Out_RobPtr = out_valid ? q_rob[rd_ptr]  : '0;
    assign bus.Out_Type   = out_valid ? q_type[rd_ptr] : 2'b00;
    assign bus.Occupancy  = occ;
endmodule

// File: tb/tb_alu_exec_pipe.sv
// tb/tb_alu_exec_pipe.sv - scoreboard bench for alu_exec_pipe with directed and random stimulus
module tb_alu_exec_pipe;
    localparam int DW = 32;
    localparam int AW = 7;
    localparam int RW = 6;
    localparam int NB = 5;
    localparam int DP = 2;

    typedef struct packed {
        logic [4:0]    op;
        logic [DW-1:0] pc;
        logic          s1a;
        logic [AW-1:0] s1addr;
        logic [DW-1:0] s1d;
        logic          s2a;
        logic [AW-1:0] s2addr;
        logic [DW-1:0] s2d;
        logic [19:0]   imm;
        logic          rda;
        logic [AW-1:0] rd;
        logic [RW-1:0] rob;
    } op_t;

    logic clk;
    logic rest;
    int   n_checks;
    int   n_pass;
    logic [47:0] exp_q[$];

    logic          last_able;
    logic [AW-1:0] last_addr;
    logic [DW-1:0] last_data;
    logic          rnd_on;

    alu_exec_pipe_if #(.DATA_W(DW), .REG_AW(AW), .ROB_AW(RW), .NUM_BYP(NB), .DEPTH(DP)) bus ();

    alu_exec_pipe #(.DATA_W(DW), .REG_AW(AW), .ROB_AW(RW), .NUM_BYP(NB), .DEPTH(DP)) dut (
        .Clk  (clk),
        .Rest (rest),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%h required=%h", nm, act, exp);
    endtask

    function automatic logic [32:0] ref_alu(input logic [4:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [31:0] pc,
                                            input logic [19:0] imm);
        logic [31:0] se;
        logic [31:0] ze;
        logic [31:0] up;
        se = {{20{imm[11]}}, imm[11:0]};
        ze = {20'h0, imm[11:0]};
        up = {imm, 12'h000};
        case (op)
            5'd0:  return {1'b0, a + b};
            5'd1:  return {1'b0, a - b};
            5'd2:  return {1'b0, a + se};
            5'd3:  return {1'b0, up};
            5'd4:  return {1'b0, 31'd0, $signed(a) < $signed(b)};
            5'd5:  return {1'b0, 31'd0, a < b};
            5'd6:  return {1'b0, 31'd0, $signed(a) < $signed(se)};
            5'd7:  return {1'b0, 31'd0, a < ze};
            5'd8:  return {1'b0, pc + up};
            5'd9:  return {1'b0, a & b};
            5'd10: return {1'b0, a | b};
            5'd11: return {1'b0, ~(a | b)};
            5'd12: return {1'b0, a ^ b};
            5'd13: return {1'b0, a & ze};
            5'd14: return {1'b0, a | ze};
            5'd15: return {1'b0, a ^ ze};
            5'd16: return {1'b0, a << b[4:0]};
            5'd17: return {1'b0, a >> b[4:0]};
            5'd18: return {1'b0, 32'($signed(a) >>> b[4:0])};
            5'd19: return {1'b0, a << imm[4:0]};
            5'd20: return {1'b0, a >> imm[4:0]};
            5'd21: return {1'b0, 32'($signed(a) >>> imm[4:0])};
            default: return {1'b1, 32'h0};
        endcase
    endfunction

    function automatic logic [DW-1:0] pick(input logic able, input logic [AW-1:0] addr,
                                           input logic [DW-1:0] rf);
        if (!able) return rf;
        if (last_able && last_addr == addr) return last_data;
        for (int c = 0; c < NB; c++)
            if (bus.Byp_Able[c] && bus.Byp_Addr[c*AW +: AW] == addr)
                return bus.Byp_Data[c*DW +: DW];
        return rf;
    endfunction

    task automatic model_push(input op_t o);
        logic [32:0] r;
        logic        able;
        r = ref_alu(o.op, pick(o.s1a, o.s1addr, o.s1d), pick(o.s2a, o.s2addr, o.s2d), o.pc, o.imm);
        able = o.rda && !r[32];
        exp_q.push_back({able, able ? o.rd : 7'd0, r[31:0], o.rob, r[32] ? 2'b11 : 2'b00});
        last_able = able;
        last_addr = o.rd;
        last_data = r[31:0];
    endtask

    task automatic drive(input op_t o);
        bus.In_Pc       = o.pc;
        bus.In_Op       = o.op;
        bus.In_Src1Able = o.s1a;
        bus.In_Src1Addr = o.s1addr;
        bus.In_Src1Data = o.s1d;
        bus.In_Src2Able = o.s2a;
        bus.In_Src2Addr = o.s2addr;
        bus.In_Src2Data = o.s2d;
        bus.In_Imm      = o.imm;
        bus.In_RdAble   = o.rda;
        bus.In_RdAddr   = o.rd;
        bus.In_RobPtr   = o.rob;
    endtask

    // Called just after a rising edge; returns just after the edge that accepted the op.
    task automatic issue(input op_t o);
        drive(o);
        bus.In_Valid = 1'b1;
        for (int t = 0; t < 64; t++) begin
            @(negedge clk);
            if (bus.In_Ready && !bus.Flush && !rest) begin
                model_push(o);
                @(posedge clk);
                #1;
                bus.In_Valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        chk("issue_timeout", 1, 0);
        bus.In_Valid = 1'b0;
    endtask

    task automatic wait_drain();
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !bus.Out_Valid) begin
                @(posedge clk);
                #1;
                return;
            end
        end
        chk("drain_timeout", 1, 0);
        @(posedge clk);
        #1;
    endtask

    function automatic op_t mk(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                               input logic [19:0] imm, input logic [6:0] rd, input logic [5:0] rob);
        op_t o;
        o = '0;
        o.op = op; o.s1d = a; o.s2d = b; o.imm = imm;
        o.rda = 1'b1; o.rd = rd; o.rob = rob;
        o.pc = 32'h1c00_0000 + 32'($urandom_range(0, 255)) * 4;
        return o;
    endfunction

    task automatic model_clear();
        exp_q.delete();
        last_able = 1'b0;
        last_addr = '0;
        last_data = '0;
    endtask

    // Monitor: compares the head against the scoreboard whenever a pop will happen.
    initial begin
        logic [47:0] e;
        logic [47:0] a;
        forever begin
            @(negedge clk);
            if (!rest && !bus.Flush && bus.Out_Valid && bus.Out_Ready) begin
                if (exp_q.size() == 0) chk("unexpected_result", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    a = {bus.Out_WBAble, bus.Out_WBAble ? bus.Out_WBAddr : 7'd0,
                         bus.Out_WBData, bus.Out_RobPtr, bus.Out_Type};
                    chk("result", a, e);
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rnd_on) bus.Out_Ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        op_t o;
        clk = 0; rest = 1; n_checks = 0; n_pass = 0; rnd_on = 0;
        bus.Flush = 0; bus.In_Valid = 0; bus.Out_Ready = 1;
        bus.Byp_Able = '0; bus.Byp_Addr = '0; bus.Byp_Data = '0;
        drive('0);
        model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", bus.Out_Valid, 0);
        chk("rst_in_ready", bus.In_Ready, 1);
        chk("rst_occupancy", bus.Occupancy, 0);
        chk("rst_head", {bus.Out_WBAble, bus.Out_WBAddr, bus.Out_WBData, bus.Out_RobPtr, bus.Out_Type}, 0);
        @(posedge clk); #1; rest = 0;

        // Signed overflow wrap.
        issue(mk(5'd0, 32'h7fff_ffff, 32'h1, 20'h0, 7'd5, 6'd9));
        @(negedge clk);
        chk("add_valid", bus.Out_Valid, 1);
        chk("add_data", bus.Out_WBData, 32'h8000_0000);
        chk("add_addr", bus.Out_WBAddr, 7'd5);
        chk("add_rob", bus.Out_RobPtr, 6'd9);
        chk("add_type", bus.Out_Type, 2'b00);
        @(posedge clk); #1;

        issue(mk(5'd21, 32'h8000_0000, 32'h0, 20'd4, 7'd3, 6'd1));
        @(negedge clk);
        chk("srai_data", bus.Out_WBData, 32'hf800_0000);
        @(posedge clk); #1;
        issue(mk(5'd6, 32'hffff_ffff, 32'h0, 20'h001, 7'd4, 6'd2));
        @(negedge clk);
        chk("slti_data", bus.Out_WBData, 32'h1);
        @(posedge clk); #1;

        // Back-to-back dependency: self-bypass beats channel 0 and the stale RF value.
        bus.Byp_Able = 5'b00001;
        bus.Byp_Addr[0 +: AW] = 7'd12;
        bus.Byp_Data[0 +: DW] = 32'h99;
        issue(mk(5'd2, 32'h0f, 32'h0, 20'h001, 7'd12, 6'd3));
        o = mk(5'd0, 32'h0, 32'h5, 20'h0, 7'd13, 6'd4);
        o.s1a = 1'b1; o.s1addr = 7'd12;
        issue(o);
        @(negedge clk);
        chk("selfbyp_data", bus.Out_WBData, 32'h15);
        @(posedge clk); #1;
        bus.Byp_Able = '0;
        wait_drain();

        // Backpressure: fill the buffer, head holds, then drain in order.
        bus.Out_Ready = 0;
        issue(mk(5'd0, 32'd1, 32'd2, 20'h0, 7'd20, 6'd20));
        issue(mk(5'd1, 32'd10, 32'd3, 20'h0, 7'd21, 6'd21));
        @(negedge clk);
        chk("full_in_ready", bus.In_Ready, 0);
        chk("full_occupancy", bus.Occupancy, DP);
        chk("full_head", bus.Out_WBData, 32'd3);
        repeat (3) @(negedge clk);
        chk("held_head", {bus.Out_WBData, bus.Out_RobPtr}, {32'd3, 6'd20});
        @(posedge clk); #1;
        bus.Out_Ready = 1;
        @(negedge clk);
        chk("drain_first", bus.Out_WBData, 32'd3);
        @(negedge clk);
        chk("drain_second", bus.Out_WBData, 32'd7);
        @(posedge clk); #1;
        wait_drain();

        // Flush with a full buffer and an op on the input.
        bus.Out_Ready = 0;
        issue(mk(5'd0, 32'd100, 32'd1, 20'h0, 7'd30, 6'd5));
        issue(mk(5'd0, 32'd200, 32'd1, 20'h0, 7'd31, 6'd6));
        drive(mk(5'd9, 32'hff, 32'h0f, 20'h0, 7'd30, 6'd7));
        bus.In_Valid = 1; bus.Flush = 1;
        @(posedge clk); #1;
        bus.In_Valid = 0; bus.Flush = 0;
        model_clear();
        @(negedge clk);
        chk("flush_occupancy", bus.Occupancy, 0);
        chk("flush_out_valid", bus.Out_Valid, 0);
        chk("flush_in_ready", bus.In_Ready, 1);
        @(posedge clk); #1;
        bus.Out_Ready = 1;
        o = mk(5'd0, 32'h5, 32'h1, 20'h0, 7'd40, 6'd8);
        o.s1a = 1'b1; o.s1addr = 7'd30;
        issue(o);
        @(negedge clk);
        chk("flush_sb_cleared", bus.Out_WBData, 32'h6);
        @(posedge clk); #1;
        issue(mk(5'd25, 32'h1234, 32'h5678, 20'h0, 7'd41, 6'd9));
        @(negedge clk);
        chk("illegal_type", bus.Out_Type, 2'b11);
        chk("illegal_wbable", bus.Out_WBAble, 0);
        chk("illegal_data", bus.Out_WBData, 0);
        @(posedge clk); #1;
        wait_drain();

        // Random traffic with random backpressure and bypass activity.
        rnd_on = 1;
        for (int i = 0; i < 300; i++) begin
            o = mk(5'($urandom_range(0, 31)), $urandom, $urandom, 20'($urandom),
                   7'($urandom_range(0, 7)), 6'($urandom));
            if ($urandom_range(0, 3) == 0) o.s1d = 32'($urandom_range(0, 40));
            o.s1a = 1'($urandom_range(0, 1)); o.s1addr = 7'($urandom_range(0, 7));
            o.s2a = 1'($urandom_range(0, 1)); o.s2addr = 7'($urandom_range(0, 7));
            o.rda = ($urandom_range(0, 7) != 0);
            bus.Byp_Able = 5'($urandom);
            for (int c = 0; c < NB; c++) begin
                bus.Byp_Addr[c*AW +: AW] = 7'($urandom_range(0, 7));
                bus.Byp_Data[c*DW +: DW] = $urandom;
            end
            issue(o);
        end
        rnd_on = 0;
        bus.Out_Ready = 1;
        bus.Byp_Able = '0;
        wait_drain();

        // Reset while full with an op on the input.
        bus.Out_Ready = 0;
        issue(mk(5'd10, 32'hf0, 32'h0f, 20'h0, 7'd2, 6'd11));
        issue(mk(5'd12, 32'hf0, 32'hff, 20'h0, 7'd3, 6'd12));
        drive(mk(5'd0, 32'h1, 32'h1, 20'h0, 7'd4, 6'd13));
        bus.In_Valid = 1; rest = 1;
        @(posedge clk); #1;
        rest = 0; bus.In_Valid = 0;
        model_clear();
        @(negedge clk);
        chk("mid_rst_occupancy", bus.Occupancy, 0);
        chk("mid_rst_valid_ready", {bus.Out_Valid, bus.In_Ready}, 2'b01);
        chk("mid_rst_head", {bus.Out_WBAble, bus.Out_WBAddr, bus.Out_WBData, bus.Out_RobPtr, bus.Out_Type}, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
